// File: rtl/vending_machine_core.sv
// ---------------------------------------------------------------------------
// vending_machine_core
//   Single-product vending controller. Product price is 15 units; accepted
//   coins are 5 and 10 units. Credit is held as one of three states
//   (0, 5, 10). A paying edge produces a one-cycle dispense pulse and, when
//   5 units of overpayment remain after the sale, a one-cycle change pulse.
//
// Ports
//   i    in  10-unit coin strobe, sampled on rising clk
//   j    in  5-unit coin strobe, sampled on rising clk
//   rst  in  asynchronous active-low reset (clears credit and pulses)
//   clk  in  rising-edge clock
//   x    out registered dispense pulse
//   y    out registered change pulse (5 units returned)
//
// Build option
//   VM_COMBO_COIN_EN  defined: {i,j}=11 counts as 15 units in one cycle.
//                     undefined: {i,j}=11 is ignored (value 0).
// ---------------------------------------------------------------------------
module vending_machine_core (
  input  logic i,
  input  logic j,
  input  logic rst,
  input  logic clk,
  output logic x,
  output logic y
);

  typedef enum logic [1:0] {
    S0  = 2'd0,
    S5  = 2'd1,
    S10 = 2'd2
  } state_t;

  localparam logic [4:0] PRICE  = 5'd15;
  localparam logic [4:0] CHANGE = 5'd5;

  state_t     state;
  state_t     next_state;
  logic       next_x;
  logic       next_y;
  logic [4:0] coin_val;
  logic [4:0] credit;
  logic [4:0] total;
  logic [4:0] rem;
  logic       state_ok;

  // Map a remaining credit amount back to a holding state. Only 0/5/10 are
  // reachable here; anything else falls back to S0.
  function automatic state_t credit_to_state(input logic [4:0] amt);
    state_t s;
    case (amt)
      5'd5:    s = S5;
      5'd10:   s = S10;
      default: s = S0;
    endcase
    return s;
  endfunction

  // Coin value decode.
  always_comb begin
    coin_val = '0;
    case ({i, j})
      2'b01:   coin_val = 5'd5;
      2'b10:   coin_val = 5'd10;
`ifdef VM_COMBO_COIN_EN
      2'b11:   coin_val = 5'd15;
`else
      2'b11:   coin_val = '0;
`endif
      default: coin_val = '0;
    endcase
  end

  // Credit held by the current state; unencoded states are flagged so they
  // recover to S0 with both pulses low.
  always_comb begin
    credit   = '0;
    state_ok = 1'b1;
    case (state)
      S0:      credit = 5'd0;
      S5:      credit = 5'd5;
      S10:     credit = 5'd10;
      default: state_ok = 1'b0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    next_state = S0;
    next_x     = 1'b0;
    next_y     = 1'b0;
    total      = credit + coin_val;
    rem        = '0;
    if (state_ok) begin
      if (total >= PRICE) begin
        next_x = 1'b1;
        rem    = total - PRICE;
        if (rem >= CHANGE) begin
          next_y = 1'b1;
          rem    = rem - CHANGE;
        end
        next_state = credit_to_state(rem);
      end else begin
        next_state = credit_to_state(total);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S0;
      x     <= 1'b0;
      y     <= 1'b0;
    end else begin
      state <= next_state;
      x     <= next_x;
      y     <= next_y;
    end
  end

endmodule

// File: tb/tb_vending_machine_core.sv
module tb_vending_machine_core;

  logic i, j, rst, clk;
  logic x, y;

  int total = 0;
  int bad   = 0;

  // Reference model: credit as a plain integer amount.
  int   m_credit = 0;
  logic exp_x    = 1'b0;
  logic exp_y    = 1'b0;

  vending_machine_core dut (
    .i  (i),
    .j  (j),
    .rst(rst),
    .clk(clk),
    .x  (x),
    .y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  function automatic int coin_value(input logic ci, input logic cj);
    if (ci && cj) begin
`ifdef VM_COMBO_COIN_EN
      return 15;
`else
      return 0;
`endif
    end
    if (ci) return 10;
    if (cj) return 5;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    int t;
    if (!rst) begin
      m_credit = 0;
      exp_x    = 1'b0;
      exp_y    = 1'b0;
    end else begin
      t     = m_credit + coin_value(i, j);
      exp_x = 1'b0;
      exp_y = 1'b0;
      if (t >= 15) begin
        exp_x = 1'b1;
        t     = t - 15;
        if (t >= 5) begin
          exp_y = 1'b1;
          t     = t - 5;
        end
      end
      m_credit = t;
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_x", x, exp_x);
    chk("cyc_y", y, exp_y);
  end

  task automatic coin(input logic ci, input logic cj);
    @(negedge clk);
    i = ci;
    j = cj;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i   = 1'b0;
    j   = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_x", x, 1'b0);
    chk("rst_y", y, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct { logic ci; logic cj; } coin_t;
  coin_t mix[] = '{
    '{1'b0,1'b1}, '{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b0,1'b1}, '{1'b0,1'b0},
    '{1'b1,1'b0}, '{1'b0,1'b1}, '{1'b0,1'b1}, '{1'b1,1'b0}, '{1'b1,1'b1},
    '{1'b0,1'b1}, '{1'b1,1'b0}, '{1'b0,1'b0}, '{1'b1,1'b0}, '{1'b1,1'b1},
    '{1'b1,1'b0}, '{1'b0,1'b1}, '{1'b1,1'b0}, '{1'b1,1'b0}, '{1'b0,1'b1}
  };

  initial begin
    i   = 1'b0;
    j   = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_x", x, 1'b0);
    chk("reset_y", y, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 10, 10 -> dispense with change on second edge
    coin(1'b1, 1'b0);
    chk("t10_x", x, 1'b0);
    chk("t10_y", y, 1'b0);
    coin(1'b1, 1'b0);
    chk("t10_10_x", x, 1'b1);
    chk("t10_10_y", y, 1'b1);
    chk_int("t10_10_credit", m_credit, 0);
    coin(1'b0, 1'b0);
    chk("pulse_clear_x", x, 1'b0);
    chk("pulse_clear_y", y, 1'b0);

    // 5, 5, 5 -> dispense on third edge only
    coin(1'b0, 1'b1);
    chk("t5_x", x, 1'b0);
    coin(1'b0, 1'b1);
    chk("t5_5_x", x, 1'b0);
    chk_int("t5_5_credit", m_credit, 10);
    coin(1'b0, 1'b1);
    chk("t5_5_5_x", x, 1'b1);
    chk("t5_5_5_y", y, 1'b0);

    // 10, idle (hold), 5 -> dispense without change
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b0);
    chk("hold_x", x, 1'b0);
    chk_int("hold_credit", m_credit, 10);
    coin(1'b0, 1'b1);
    chk("s10_5_x", x, 1'b1);
    chk("s10_5_y", y, 1'b0);

    // 5, 10 -> dispense without change
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    chk("s5_10_x", x, 1'b1);
    chk("s5_10_y", y, 1'b0);

`ifndef VM_COMBO_COIN_EN
    // 11 is ignored: no pulse, credit stays 0 (5 then 10 needed to pay)
    do_reset();
    coin(1'b1, 1'b1);
    chk("inv11_x", x, 1'b0);
    chk("inv11_y", y, 1'b0);
    coin(1'b0, 1'b1);
    chk("inv11_then5_x", x, 1'b0);
    coin(1'b1, 1'b0);
    chk("inv11_then5_10_x", x, 1'b1);
    chk("inv11_then5_10_y", y, 1'b0);
`else
    // 10 then 11 -> x, y, left with 5; 00 holds; 10 then pays without change
    do_reset();
    coin(1'b1, 1'b0);
    coin(1'b1, 1'b1);
    chk("c10_11_x", x, 1'b1);
    chk("c10_11_y", y, 1'b1);
    chk_int("c10_11_credit", m_credit, 5);
    coin(1'b0, 1'b0);
    chk("c_hold_x", x, 1'b0);
    chk("c_hold_y", y, 1'b0);
    coin(1'b1, 1'b0);
    chk("c_s5_10_x", x, 1'b1);
    chk("c_s5_10_y", y, 1'b0);
    // 11, 11 -> back-to-back dispense, no change
    do_reset();
    coin(1'b1, 1'b1);
    chk("c11a_x", x, 1'b1);
    chk("c11a_y", y, 1'b0);
    coin(1'b1, 1'b1);
    chk("c11b_x", x, 1'b1);
    chk("c11b_y", y, 1'b0);
`endif

    // Mid-cycle reset discards credit of 10; then 5 leaves 5, and 10 pays
    do_reset();
    coin(1'b1, 1'b0);
    @(negedge clk);
    i = 1'b0;
    j = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_x", x, 1'b0);
    chk("midrst_y", y, 1'b0);
    chk_int("midrst_credit", m_credit, 0);
    @(negedge clk);
    rst = 1'b1;
    coin(1'b0, 1'b1);
    chk("after_rst5_x", x, 1'b0);
    coin(1'b1, 1'b0);
    chk("after_rst5_10_x", x, 1'b1);
    chk("after_rst5_10_y", y, 1'b0);

    // Mixed sequence checked by the cycle compare
    foreach (mix[k]) coin(mix[k].ci, mix[k].cj);
    coin(1'b0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_machine_core.md
VENDING_MACHINE_CORE -- requirements
Module: vending_machine

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports in order i, j, rst, clk, x, y.
REQ-002 clk  input  1  rising-edge clock; all state and outputs update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 i  input  1  10-unit coin strobe, sampled each rising clk edge.
REQ-005 j  input  1  5-unit coin strobe, sampled each rising clk edge.
REQ-006 x  output  1  dispense pulse, registered, high for one cycle per product sold.
REQ-007 y  output  1  change pulse, registered, high for one cycle when 5 units are returned.

Function
REQ-008 SHALL sell one product priced at 15 units and hold credit in states S0, S5 and S10 (credit 0, 5 and 10).
REQ-009 SHALL decode the coin value v from {i,j}:
- 00 -> 0
- 01 -> 5
- 10 -> 10
- 11 -> per REQ-020
REQ-010 Each edge, total = credit + v; if total < 15, next state = total, and x and y are 0.
REQ-011 If total >= 15: x = 1 and rem = total - 15.
- If rem >= 5: y = 1 and rem = rem - 5.
- Next state = rem (S0 or S5).
REQ-012 The full transition table SHALL be:
- S0: 5 -> S5; 10 -> S10; 15 -> S0 with x.
- S5: 5 -> S10; 10 -> S0 with x; 15 -> S0 with x, y.
- S10: 5 -> S0 with x; 10 -> S0 with x, y; 15 -> S5 with x, y.
REQ-013 v = 0 SHALL hold the state, with x = 0 and y = 0.
REQ-014 x and y SHALL be flops, asserted in the cycle after the paying edge and cleared on the next edge unless it is again a paying edge.
REQ-015 Back-to-back paying edges SHALL give back-to-back pulses, with no lost credit.
REQ-016 Unencoded state values SHALL recover to S0 on the next edge, with x = 0 and y = 0.

Reset
REQ-017 While rst = 0, the state SHALL be S0 and x = 0, y = 0, asynchronously to clk.
REQ-018 Reset asserted mid-transaction SHALL discard the held credit, and no change is returned.
REQ-019 After rst deasserts, the first rising edge SHALL sample coins normally.

Configuration
REQ-020 Macro VM_COMBO_COIN_EN:
- Defined: {i,j} = 11 SHALL count as v = 15 (both coins inserted in one cycle).
- Undefined: 11 SHALL be treated as invalid, with v = 0, the state held, and x and y at 0.

Verification
REQ-021 Reset -> 10, 10 -> after the second edge x = 1, y = 1, state S0.
REQ-022 Reset -> 5, 5, 5 -> x = 1 and y = 0 after the third edge only; state S0.
REQ-023 Reset -> 10, then 11 with the macro defined -> x = 1, y = 1, state S5; then 00 -> state S5, x = 0, y = 0.
REQ-024 Reset -> 11 with the macro undefined -> state S0, x = 0, y = 0.
REQ-025 Reset -> 10, then rst = 0 mid-cycle -> state S0 immediately, x = 0, y = 0; then 5 -> state S5.
REQ-026 Reset -> 11, 11 with the macro defined -> two consecutive x pulses, y = 0 both cycles.
